// File: rtl/serial_io_bus_arbiter.sv
// Round-robin arbiter that shares the byte-wide 16550 serial IO bus among NUM_REQ requesters.
// Each outputs register reflects the state held at that clock edge, so the bus strobes trail the FSM state by one cycle.
module serial_io_bus_arbiter #(
    parameter int          NUM_REQ       = 4,
    parameter int          ACCESS_CYCLES = 3,
    parameter logic [15:0] BASE_ADDR     = 16'h0200
) (
    input  logic                   Clock,
    input  logic                   Reset_H,
    input  logic [NUM_REQ-1:0]     Req,
    input  logic [3*NUM_REQ-1:0]   Req_Port,
    input  logic [3*NUM_REQ-1:0]   Req_Reg,
    input  logic [NUM_REQ-1:0]     Req_Write,
    input  logic [8*NUM_REQ-1:0]   Req_WData,
    output logic [NUM_REQ-1:0]     Done,
    output logic                   Err,
    output logic [7:0]             RData,
    output logic                   Busy,
    output logic [15:0]            Address,
    output logic                   IOSelect_H,
    output logic                   ByteSelect_L,
    output logic                   Write_L,
    output logic [7:0]             Bus_WData,
    input  logic [7:0]             Bus_RData
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

    state_t                    state;
    logic [NUM_REQ-1:0][2:0]   port_v;
    logic [NUM_REQ-1:0][2:0]   reg_v;
    logic [NUM_REQ-1:0][7:0]   wdata_v;
    logic [IW-1:0]             ptr;
    logic [IW-1:0]             win;
    logic [IW-1:0]             cand;
    logic [2:0]                port_q;
    logic [2:0]                reg_q;
    logic                      wr_q;
    logic                      bad_q;
    logic [7:0]                wd_q;
    logic [3:0]                cnt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign port_v[g]  = Req_Port[3*g +: 3];
        assign reg_v[g]   = Req_Reg[3*g +: 3];
        assign wdata_v[g] = Req_WData[8*g +: 8];
    end

    // Scan from farthest to nearest so the first requester after ptr wins.
    always_comb begin
        win  = ptr;
        cand = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IW'((int'(ptr) + i) % NUM_REQ);
            if (Req[cand]) win = cand;
        end
    end

    always_ff @(posedge Clock or posedge Reset_H) begin
        if (Reset_H) begin
            state        <= IDLE;
            ptr          <= IW'(NUM_REQ - 1);
            port_q       <= '0;
            reg_q        <= '0;
            wr_q         <= 1'b0;
            bad_q        <= 1'b0;
            wd_q         <= '0;
            cnt          <= '0;
            Address      <= '0;
            IOSelect_H   <= 1'b0;
            ByteSelect_L <= 1'b1;
            Write_L      <= 1'b1;
            Bus_WData    <= '0;
            Done         <= '0;
            Err          <= 1'b0;
            RData        <= '0;
            Busy         <= 1'b0;
        end else begin
            Done <= '0;
            Err  <= 1'b0;
            Busy <= (state != IDLE);
            case (state)
                IDLE: begin
                    ByteSelect_L <= 1'b1;
                    IOSelect_H   <= 1'b0;
                    Write_L      <= 1'b1;
                    if (|Req) begin
                        ptr    <= win;
                        port_q <= port_v[win];
                        reg_q  <= reg_v[win];
                        wr_q   <= Req_Write[win];
                        wd_q   <= wdata_v[win];
                        bad_q  <= &port_v[win];
                        // Port 7 has no UART behind it: skip the bus cycle entirely.
                        state  <= (&port_v[win]) ? RECOVER : SETUP;
                    end
                end
                SETUP: begin
                    Address      <= BASE_ADDR + {9'b0, port_q, 4'b0} + {12'b0, reg_q, 1'b0};
                    IOSelect_H   <= 1'b1;
                    Write_L      <= ~wr_q;
                    Bus_WData    <= wr_q ? wd_q : 8'h00;
                    ByteSelect_L <= 1'b1;
                    cnt          <= 4'(ACCESS_CYCLES - 1);
                    state        <= ACCESS;
                end
                ACCESS: begin
                    ByteSelect_L <= 1'b0;
                    if (cnt == 4'd0) state <= RECOVER;
                    else             cnt   <= cnt - 4'd1;
                end
                RECOVER: begin
                    ByteSelect_L <= 1'b1;
                    IOSelect_H   <= 1'b0;
                    Write_L      <= 1'b1;
                    Done[ptr]    <= 1'b1;
                    Err          <= bad_q;
                    // This edge ends the final strobe-low cycle; read data is sampled here.
                    if (!wr_q && !bad_q) RData <= Bus_RData;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_io_bus_arbiter.sv
// Directed and randomized checks of serial_io_bus_arbiter against a transaction-level model.
module tb_serial_io_bus_arbiter;
    localparam int NR = 4;
    localparam int AC = 3;

    logic            Clock = 1'b0;
    logic            Reset_H;
    logic [NR-1:0]   Req;
    logic [3*NR-1:0] Req_Port, Req_Reg;
    logic [NR-1:0]   Req_Write;
    logic [8*NR-1:0] Req_WData;
    logic [7:0]      Bus_RData;
    logic [NR-1:0]   Done, Done_1;
    logic            Err, Err_1, Busy, Busy_1;
    logic [7:0]      RData, RData_1, Bus_WData, Bus_WData_1;
    logic [15:0]     Address, Address_1;
    logic            IOSelect_H, IOSelect_H_1, ByteSelect_L, ByteSelect_L_1, Write_L, Write_L_1;

    always #5 Clock = ~Clock;

    serial_io_bus_arbiter #(.NUM_REQ(NR), .ACCESS_CYCLES(AC), .BASE_ADDR(16'h0200)) dut (
        .Clock(Clock), .Reset_H(Reset_H), .Req(Req), .Req_Port(Req_Port), .Req_Reg(Req_Reg),
        .Req_Write(Req_Write), .Req_WData(Req_WData), .Done(Done), .Err(Err), .RData(RData),
        .Busy(Busy), .Address(Address), .IOSelect_H(IOSelect_H), .ByteSelect_L(ByteSelect_L),
        .Write_L(Write_L), .Bus_WData(Bus_WData), .Bus_RData(Bus_RData));

    serial_io_bus_arbiter #(.NUM_REQ(NR), .ACCESS_CYCLES(1), .BASE_ADDR(16'h0200)) dut1 (
        .Clock(Clock), .Reset_H(Reset_H), .Req(Req), .Req_Port(Req_Port), .Req_Reg(Req_Reg),
        .Req_Write(Req_Write), .Req_WData(Req_WData), .Done(Done_1), .Err(Err_1), .RData(RData_1),
        .Busy(Busy_1), .Address(Address_1), .IOSelect_H(IOSelect_H_1), .ByteSelect_L(ByteSelect_L_1),
        .Write_L(Write_L_1), .Bus_WData(Bus_WData_1), .Bus_RData(Bus_RData));

    int         n_tests = 0;
    int         n_fail  = 0;
    int         model_ptr;
    logic [2:0] f_port [NR];
    logic [2:0] f_reg  [NR];
    logic       f_wr   [NR];
    logic [7:0] f_wd   [NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            Req_Port[3*i +: 3]  = f_port[i];
            Req_Reg[3*i +: 3]   = f_reg[i];
            Req_Write[i]        = f_wr[i];
            Req_WData[8*i +: 8] = f_wd[i];
        end
    endtask

    task automatic rand_fields(input int i);
        f_port[i] = 3'($urandom_range(0, 7));
        f_reg[i]  = 3'($urandom_range(0, 7));
        f_wr[i]   = 1'($urandom_range(0, 1));
        f_wd[i]   = 8'($urandom);
    endtask

    function automatic logic [15:0] exp_addr(input logic [2:0] p, input logic [2:0] r);
        return 16'h0200 + 16'(p) * 16'd16 + 16'(r) * 16'd2;
    endfunction

    // One requester alone on an idle bus; Req is dropped right after the sampling edge.
    task automatic single(input string tag, input int idx, input logic [2:0] p, input logic [2:0] r,
                          input logic wr, input logic [7:0] wd, input logic [7:0] rd);
        int            done_t = 0, bs_low = 0, ios_hi = 0;
        logic          got = 1'b0, err_s = 1'b0, busy_s = 1'b0, wl_s = 1'b1;
        logic [15:0]   a_s = '0;
        logic [7:0]    wd_s = '0, rd_s = '0;
        logic [NR-1:0] done_s = '0;
        logic          valid = (p != 3'd7);
        f_port[idx] = p; f_reg[idx] = r; f_wr[idx] = wr; f_wd[idx] = wd;
        apply();
        Bus_RData = rd;
        Req = '0;
        Req[idx] = 1'b1;
        tick();
        Req = '0;
        for (int t = 1; t <= AC + 4; t++) begin
            tick();
            if (!ByteSelect_L) bs_low++;
            if (IOSelect_H) begin
                ios_hi++;
                if (!got) begin a_s = Address; wl_s = Write_L; wd_s = Bus_WData; got = 1'b1; end
            end
            if (Done != '0 && done_t == 0) begin
                done_t = t; done_s = Done; err_s = Err; rd_s = RData; busy_s = Busy;
                Bus_RData = ~rd;
            end
        end
        chk({tag, "_latency"}, done_t, valid ? AC + 2 : 1);
        chk({tag, "_done"}, done_s, 1 << idx);
        chk({tag, "_err"}, err_s, !valid);
        chk({tag, "_busy"}, busy_s, 1);
        chk({tag, "_bs_low"}, bs_low, valid ? AC : 0);
        chk({tag, "_iosel"}, ios_hi, valid ? AC + 1 : 0);
        if (valid) begin
            chk({tag, "_addr"}, a_s, exp_addr(p, r));
            chk({tag, "_write_l"}, wl_s, !wr);
            chk({tag, "_bus_wdata"}, wd_s, wr ? wd : 8'h00);
            if (!wr) begin
                chk({tag, "_rdata"}, rd_s, rd);
                chk({tag, "_rdata_hold"}, RData, rd);
            end
        end
        model_ptr = idx;
    endtask

    initial begin
        int         ndone, cyc, prev_t, w, rst_done;
        logic [7:0] rd_exp;
        logic [NR-1:0] first;

        Reset_H = 1'b1; Req = '0; Bus_RData = '0;
        for (int i = 0; i < NR; i++) begin f_port[i] = '0; f_reg[i] = '0; f_wr[i] = 1'b0; f_wd[i] = '0; end
        apply();
        tick(); tick();
        chk("rst_addr", Address, 0);
        chk("rst_iosel", IOSelect_H, 0);
        chk("rst_bsel", ByteSelect_L, 1);
        chk("rst_write_l", Write_L, 1);
        chk("rst_bus_wdata", Bus_WData, 0);
        chk("rst_done", Done, 0);
        chk("rst_err", Err, 0);
        chk("rst_rdata", RData, 0);
        chk("rst_busy", Busy, 0);
        Reset_H = 1'b0;
        model_ptr = NR - 1;
        tick(); tick();

        single("wr_p1r3", 0, 3'd1, 3'd3, 1'b1, 8'hA5, 8'h00);
        tick(); tick();
        single("rd_p0r5", 2, 3'd0, 3'd5, 1'b0, 8'h77, 8'h60);
        tick(); tick();
        single("bad_port", 1, 3'd7, 3'd2, 1'b1, 8'h11, 8'h00);
        tick(); tick();

        // All requesters held continuously, each presenting a fresh random request after its Done.
        for (int i = 0; i < NR; i++) rand_fields(i);
        apply();
        Bus_RData = 8'($urandom);
        rd_exp = Bus_RData;
        Req = '1;
        ndone = 0; cyc = 0; prev_t = -1;
        while (ndone < 12 && cyc < 400) begin
            tick();
            cyc++;
            if (Done != '0) begin
                w = (model_ptr + 1) % NR;
                chk("rr_grant", Done, 1 << w);
                chk("rr_err", Err, f_port[w] == 3'd7);
                if (f_port[w] != 3'd7) chk("rr_addr", Address, exp_addr(f_port[w], f_reg[w]));
                if (f_port[w] != 3'd7 && !f_wr[w]) chk("rr_rdata", RData, rd_exp);
                if (prev_t >= 0) chk("rr_gap", cyc - prev_t, (f_port[w] == 3'd7) ? 2 : AC + 3);
                prev_t = cyc;
                model_ptr = w;
                ndone++;
                rand_fields(w);
                apply();
                Bus_RData = 8'($urandom);
                rd_exp = Bus_RData;
            end
        end
        chk("rr_count", ndone, 12);
        Req = '0;
        tick(); tick(); tick(); tick(); tick(); tick(); tick();

        // Reset in the second strobe-low cycle aborts the transfer silently.
        f_port[2] = 3'd3; f_reg[2] = 3'd0; f_wr[2] = 1'b1; f_wd[2] = 8'h5A;
        apply();
        Req = '0; Req[2] = 1'b1;
        tick();
        Req = '0;
        tick(); tick(); tick();
        #2;
        Reset_H = 1'b1;
        #1;
        chk("arst_bsel", ByteSelect_L, 1);
        chk("arst_iosel", IOSelect_H, 0);
        chk("arst_busy", Busy, 0);
        chk("arst_addr", Address, 0);
        rst_done = 0;
        for (int t = 0; t < 3; t++) begin tick(); if (Done != '0) rst_done++; end
        Reset_H = 1'b0;
        model_ptr = NR - 1;
        f_port[0] = 3'd4; f_reg[0] = 3'd2; f_wr[0] = 1'b0;
        f_port[3] = 3'd5; f_reg[3] = 3'd1; f_wr[3] = 1'b1;
        apply();
        Req = 4'b1001;
        first = '0;
        for (int t = 0; t < 20 && first == '0; t++) begin
            tick();
            if (Done != '0) begin first = Done; Req = '0; end
        end
        chk("arst_no_done", rst_done, 0);
        chk("arst_first_grant", first, 4'b0001);
        Req = '0;
        tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();

        // Single-cycle access, requester 3 holds Req across its Done (checked on dut1).
        f_port[3] = 3'd2; f_reg[3] = 3'd1; f_wr[3] = 1'b1; f_wd[3] = 8'h3C;
        apply();
        Req = '0; Req[3] = 1'b1;
        tick();
        begin
            int       d1 = 0, d2 = 0, bsl = 0;
            logic     ios4 = 1'b1;
            logic [15:0] a5 = '0;
            for (int t = 1; t <= 9; t++) begin
                tick();
                if (!ByteSelect_L_1) bsl++;
                if (t == 4) ios4 = IOSelect_H_1;
                if (t == 5) a5 = Address_1;
                if (Done_1 != '0) begin
                    if (d1 == 0) begin d1 = t; chk("ac1_done_idx", Done_1, 4'b1000); end
                    else if (d2 == 0) begin d2 = t; Req = '0; end
                end
            end
            chk("ac1_first_done", d1, 3);
            chk("ac1_second_done", d2, 7);
            chk("ac1_bs_low", bsl, 2);
            chk("ac1_gap_iosel", ios4, 0);
            chk("ac1_addr", a5, 16'h0222);
        end
        Req = '0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
